// File: rtl/dmem_responder.sv
// Word-organized data-memory responder for the LSU: byte-maskable on-chip RAM
// behind valid/ready request and response channels, with a fixed access latency.
module dmem_responder #(
  parameter int unsigned        XLEN      = 32,
  parameter int unsigned        DEPTH     = 1024,
  parameter logic [XLEN-1:0]    BASE_ADDR = XLEN'(32'h8000_0000),
  parameter int unsigned        LATENCY   = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [3:0]      req_wmask_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = 4;
  localparam int unsigned NLANE = 4;
  localparam logic [XLEN-1:0] SPAN     = XLEN'(4 * DEPTH);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              accept, access;

  logic              we_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [3:0]        wmask_q;

  logic [XLEN-1:0]   offset;
  logic              in_range;
  logic [AW-1:0]     idx;

  logic [XLEN-1:0]   mem [DEPTH];

  // Range check and word index come from the latched request address.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && (offset < SPAN);
  assign idx      = offset[AW+1:2];

  // Next-state and strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch and registered response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_o <= (state_d == IDLE);
      rsp_valid_o <= (state_d == RESP);
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        wmask_q <= req_wmask_i;
      end
      if (access) begin
        rsp_err_o   <= !in_range;
        rsp_rdata_o <= (in_range && !we_q) ? mem[idx] : '0;
      end
    end
  end

  // Storage is deliberately unreset; only enabled lanes of in-range stores change.
  always_ff @(posedge clk_i) begin
    if (access && we_q && in_range) begin
      for (int i = 0; i < NLANE; i++) begin
        if (wmask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance 0 runs LATENCY=2, instance 1 LATENCY=4.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0 (LATENCY = 2)
  logic        rst0_n, req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
  logic [3:0]  req_wmask0;
  // Instance 1 (LATENCY = 4)
  logic        rst1_n, req_valid1, req_ready1, req_we1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
  logic [3:0]  req_wmask1;

  dmem_responder #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst0_n),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(req_we0),
    .req_addr_i(req_addr0), .req_wdata_i(req_wdata0), .req_wmask_i(req_wmask0),
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0), .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0)
  );

  dmem_responder #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst1_n),
    .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_we_i(req_we1),
    .req_addr_i(req_addr1), .req_wdata_i(req_wdata1), .req_wmask_i(req_wmask1),
    .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1), .rsp_rdata_o(rsp_rdata1), .rsp_err_o(rsp_err1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? req_ready0 : req_ready1;
  endfunction
  function automatic logic vld(input int s);
    return (s == 0) ? rsp_valid0 : rsp_valid1;
  endfunction
  function automatic logic [31:0] rdat(input int s);
    return (s == 0) ? rsp_rdata0 : rsp_rdata1;
  endfunction
  function automatic logic errv(input int s);
    return (s == 0) ? rsp_err0 : rsp_err1;
  endfunction

  task automatic drive(input int s, input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    if (s == 0) begin
      req_valid0 = v; req_we0 = we; req_addr0 = a; req_wdata0 = d; req_wmask0 = m;
    end else begin
      req_valid1 = v; req_we1 = we; req_addr1 = a; req_wdata1 = d; req_wmask1 = m;
    end
  endtask

  task automatic set_rsp_ready(input int s, input logic r);
    if (s == 0) rsp_ready0 = r;
    else        rsp_ready1 = r;
  endtask

  // Monitors: pop and compare whenever a response handshake is presented.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst0_n && rsp_valid0 && rsp_ready0) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_rsp0: got rdata %h err %b expected no response", rsp_rdata0, rsp_err0);
      end else begin
        e = q0.pop_front();
        check("rsp0_rdata", rsp_rdata0, e[32:1]);
        check("rsp0_err", 32'(rsp_err0), 32'(e[0]));
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst1_n && rsp_valid1 && rsp_ready1) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_rsp1: got rdata %h err %b expected no response", rsp_rdata1, rsp_err1);
      end else begin
        e = q1.pop_front();
        check("rsp1_rdata", rsp_rdata1, e[32:1]);
        check("rsp1_err", 32'(rsp_err1), 32'(e[0]));
      end
    end
  end

  // One full transaction; hold > 0 applies response backpressure for that many cycles.
  task automatic send(input int s, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic [31:0] er, input logic ee, input int hold);
    int k;
    int lat;
    lat = (s == 0) ? 2 : 4;
    @(negedge clk);
    check($sformatf("ready_idle_s%0d", s), 32'(rdy(s)), 32'd1);
    if (s == 0) q0.push_back({er, ee});
    else        q1.push_back({er, ee});
    drive(s, 1'b1, we, a, d, m);
    set_rsp_ready(s, (hold == 0));
    @(posedge clk);
    #1;
    drive(s, 1'b0, ~we, 32'hFFFF_FFFF, ~d, 4'hF);
    k = 0;
    while (!vld(s) && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check($sformatf("latency_s%0d", s), 32'(k), 32'(lat));
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
        check("bp_valid", 32'(vld(s)), 32'd1);
        check("bp_rdata", rdat(s), er);
        check("bp_err", 32'(errv(s)), 32'(ee));
        check("bp_ready", 32'(rdy(s)), 32'd0);
      end
      set_rsp_ready(s, 1'b1);
    end
    @(posedge clk);
    #1;
    check("post_hs_ready", 32'(rdy(s)), 32'd1);
    check("post_hs_valid", 32'(vld(s)), 32'd0);
  endtask

  initial begin
    int k;
    int cnt;
    rst0_n = 1'b1; rst1_n = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    #2;
    rst0_n = 1'b0; rst1_n = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready0), 32'd1);
    check("rst_valid", 32'(rsp_valid0), 32'd0);
    check("rst_rdata", rsp_rdata0, 32'd0);
    check("rst_err", 32'(rsp_err0), 32'd0);
    @(negedge clk);
    rst0_n = 1'b1; rst1_n = 1'b1;

    // Word store/load, byte/half masks and ignored low address bits
    send(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0, 0);
    send(0, 1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0, 0);
    send(0, 1'b1, 32'h8000_0010, 32'h0000_5500, 4'b0010, 32'h0, 1'b0, 0);
    send(0, 1'b1, 32'h8000_0010, 32'h1234_0000, 4'b1100, 32'h0, 1'b0, 0);
    send(0, 1'b0, 32'h8000_0013, 32'h0,         4'b1111, 32'h1234_55EF, 1'b0, 0);
    // Zero mask changes nothing
    send(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 0);
    send(0, 1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'h1234_55EF, 1'b0, 0);
    // Range edges: last word in range, just below base, one past the end
    send(0, 1'b1, 32'h8000_0000, 32'hA5A5_5A5A, 4'b1111, 32'h0, 1'b0, 0);
    send(0, 1'b1, 32'h8000_0FFC, 32'h0BAD_F00D, 4'b1111, 32'h0, 1'b0, 0);
    send(0, 1'b0, 32'h8000_0FFC, 32'h0,         4'b0000, 32'h0BAD_F00D, 1'b0, 0);
    send(0, 1'b0, 32'h7FFF_FFFC, 32'h0,         4'b0000, 32'h0, 1'b1, 0);
    send(0, 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1, 0);
    send(0, 1'b0, 32'h8000_0000, 32'h0,         4'b0000, 32'hA5A5_5A5A, 1'b0, 0);
    // Backpressure
    send(0, 1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'h1234_55EF, 1'b0, 5);

    // Asynchronous reset mid-cycle while a response is being held
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
    rsp_ready0 = 1'b0;
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    k = 0;
    while (!rsp_valid0 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("pre_rst_rdata", rsp_rdata0, 32'h1234_55EF);
    #2;
    rst0_n = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready0), 32'd1);
    check("midrst_valid", 32'(rsp_valid0), 32'd0);
    check("midrst_rdata", rsp_rdata0, 32'd0);
    check("midrst_err", 32'(rsp_err0), 32'd0);
    @(negedge clk);
    rst0_n = 1'b1;
    rsp_ready0 = 1'b1;

    // LATENCY=4: reset two cycles into a store drops it without a response
    send(1, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'b1111, 32'h0, 1'b0, 0);
    send(1, 1'b0, 32'h8000_0020, 32'h0,         4'b0000, 32'h1122_3344, 1'b0, 0);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'b1111);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst1_n = 1'b0;
    #1;
    check("drop_rst_ready", 32'(req_ready1), 32'd1);
    #1;
    rst1_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid1) cnt++;
    end
    check("drop_no_rsp", 32'(cnt), 32'd0);
    send(1, 1'b0, 32'h8000_0020, 32'h0, 4'b0000, 32'h1122_3344, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-organized data-memory responder that serves the load/store unit's memory requests over a valid/ready request channel and a valid/ready response channel. It holds a byte-maskable on-chip RAM and models a fixed access latency with a counter-driven FSM. It sits on the memory side of the LSU in place of the simulation-only pmem read/write path, so the core can run against synthesizable storage.

## Interface
Parameters:
- XLEN, 32: data and address width.
- DEPTH, 1024: number of XLEN-bit words of storage.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- LATENCY, 2: cycles from request acceptance to response valid; legal range is 1..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  XLEN  byte address; bits [1:0] are ignored, because the word index is (addr − BASE_ADDR) >> 2.
- req_wdata_i  in  XLEN  store data, already lane-aligned by the requester.
- req_wmask_i  in  4  byte-lane write enables; bit i enables wdata[8i+7:8i].
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  requester accepts the response.
- rsp_rdata_o  out  XLEN  full word read; the requester performs lane select and extension.
- rsp_err_o  out  1  request address was out of range.

## Operation
- The FSM has three states: IDLE, BUSY and RESP.
  - IDLE: req_ready_o = 1. When req_valid_i is high, the block latches we, addr, wdata and wmask, loads the counter with LATENCY−1 and goes to BUSY.
  - BUSY: req_ready_o = 0. The counter decrements each cycle. When the counter is 0, the block performs the access, registers the result and goes to RESP.
  - RESP: rsp_valid_o = 1. When rsp_ready_i is high, the block goes to IDLE. Otherwise it stays, and rsp_rdata_o and rsp_err_o hold stable.
- Range check: the address is in range iff BASE_ADDR ≤ addr < BASE_ADDR + 4·DEPTH, compared as unsigned XLEN-bit values.
- Store, in range: each enabled byte lane of the word is written; disabled lanes keep their old value. rsp_rdata_o = 0 and rsp_err_o = 0. A mask of 4'b0000 is legal, changes nothing and gives rsp_err_o = 0.
- Load, in range: rsp_rdata_o = the stored word as it stands at the access edge. wmask is ignored.
- Out of range, load or store: no RAM write, rsp_rdata_o = 0, rsp_err_o = 1.
- One request is outstanding at most. Request inputs are ignored in any state other than IDLE.
- RAM contents are not reset and are X until written. Outputs do not depend on RAM contents except through rsp_rdata_o on a load.

## Timing
- Reset values: state = IDLE, req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, counter = 0.
- Acceptance at edge T, meaning req_valid_i & req_ready_o are sampled high:
  - the RAM access and the output registers update at edge T+LATENCY;
  - rsp_valid_o is high from the cycle after T+LATENCY onward.
  - With LATENCY = 1, the access happens at edge T+1 with no idle BUSY cycle.
- Response handshake at edge R: rsp_valid_o falls after R and req_ready_o rises after R. The next request can be accepted at edge R+1 at the earliest.
  - Full-throughput period is therefore LATENCY+2 cycles per request when rsp_ready_i is held high.
- A store is architecturally visible to a load accepted after the store's response handshake.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and the pending request is dropped.
  - If reset hits before the access edge, no write occurs.
  - If reset hits after the access edge, the write has already been committed.
- req_ready_o and rsp_valid_o are decoded purely from state; there are no combinational input-to-output paths.

## Test plan
- Reset: assert rst_ni = 0 asynchronously mid-cycle → req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0 and rsp_err_o = 0 immediately, without waiting for a clock edge.
- Word store/load with LATENCY = 2, rsp_ready_i = 1:
  - store 32'hDEADBEEF to 32'h8000_0010 with mask 4'b1111 → rsp_valid_o is first high 2 cycles after acceptance, rsp_err_o = 0;
  - load from 32'h8000_0010 → rsp_rdata_o = 32'hDEADBEEF.
- Byte and half masks: after the word above:
  - store 32'h0000_5500 with mask 4'b0010, then 32'h1234_0000 with mask 4'b1100;
  - load from 32'h8000_0013 → 32'h1234_55EF, with address bits [1:0] ignored.
- Out of range: load from 32'h7FFF_FFFC, then store to 32'h8000_1000 with DEPTH = 1024 → both give rsp_err_o = 1 and rsp_rdata_o = 0, and a reload of word 0 is unchanged.
- Backpressure: hold rsp_ready_i = 0 for 5 cycles after rsp_valid_o rises → outputs stay stable and req_ready_o = 0. Then raise rsp_ready_i → req_ready_o = 1 on the following cycle.
- Reset mid-BUSY: store 32'hFFFF_FFFF with LATENCY = 4, and pulse rst_ni low 2 cycles after acceptance → a reload returns the pre-store value, and no response is ever issued for the dropped store.
